// File: rtl/score_display.sv
// score_display: watches {level, score}. On any change it converts both values
// to BCD with a serial shift-add-3 (one shift per clk), then commits eight
// 7-segment patterns: five score digits on hex0..hex4, three level digits on hex5..hex7.
// The FSM state is visible on state_dbg.
module score_display #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic [7:0]  level,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCORE  = 2'd1,
        S_LEVEL  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_ZERO = ACTIVE_LOW ? 7'h40 : 7'h3F;
    // Reset pattern for every digit except the ones digit of each group.
    localparam logic [6:0] SEG_RST_HI = BLANK_LZ ? SEG_OFF : SEG_ZERO;

    state_t      state;
    logic [23:0] last;      // last committed {level, score}
    logic [23:0] capt;      // value captured when the conversion started
    logic [23:0] shadow;    // shifting copy of capt
    logic [19:0] bcd_s;
    logic [11:0] bcd_l;
    logic [4:0]  cnt;

    logic [19:0] bcd_s_adj;
    logic [11:0] bcd_l_adj;
    logic [6:0]  pat_s [5];
    logic [6:0]  pat_l [3];
    logic        seen_s;
    logic        seen_l;

    // Active-high segment pattern for a decimal digit (bit0 = a ... bit6 = g).
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Apply output polarity.
    function automatic logic [6:0] drive(input logic [6:0] p);
        drive = ACTIVE_LOW ? ~p : p;
    endfunction

    assign state_dbg = state;

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        bcd_s_adj = bcd_s;
        bcd_l_adj = bcd_l;
        for (int i = 0; i < 5; i++) begin
            if (bcd_s[4*i +: 4] >= 4'd5) bcd_s_adj[4*i +: 4] = bcd_s[4*i +: 4] + 4'd3;
        end
        for (int i = 0; i < 3; i++) begin
            if (bcd_l[4*i +: 4] >= 4'd5) bcd_l_adj[4*i +: 4] = bcd_l[4*i +: 4] + 4'd3;
        end
    end

    // Segment patterns with leading-zero blanking, scanned from the most-significant digit down.
    always_comb begin
        seen_s = 1'b0;
        seen_l = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (bcd_s[4*i +: 4] != 4'd0) seen_s = 1'b1;
            if (BLANK_LZ && !seen_s && i != 0) pat_s[i] = SEG_OFF;
            else                               pat_s[i] = drive(seg7(bcd_s[4*i +: 4]));
        end
        for (int i = 2; i >= 0; i--) begin
            if (bcd_l[4*i +: 4] != 4'd0) seen_l = 1'b1;
            if (BLANK_LZ && !seen_l && i != 0) pat_l[i] = SEG_OFF;
            else                               pat_l[i] = drive(seg7(bcd_l[4*i +: 4]));
        end
    end

    // Conversion FSM with registered display, busy and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            last   <= 24'd0;
            capt   <= 24'd0;
            shadow <= 24'd0;
            bcd_s  <= 20'd0;
            bcd_l  <= 12'd0;
            cnt    <= 5'd0;
            hex0   <= SEG_ZERO;
            hex1   <= SEG_RST_HI;
            hex2   <= SEG_RST_HI;
            hex3   <= SEG_RST_HI;
            hex4   <= SEG_RST_HI;
            hex5   <= SEG_ZERO;
            hex6   <= SEG_RST_HI;
            hex7   <= SEG_RST_HI;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ({level, score} != last) begin
                        shadow <= {level, score};
                        capt   <= {level, score};
                        bcd_s  <= 20'd0;
                        bcd_l  <= 12'd0;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= S_SCORE;
                    end
                end
                S_SCORE: begin
                    bcd_s         <= {bcd_s_adj[18:0], shadow[15]};
                    shadow[15:0]  <= {shadow[14:0], 1'b0};
                    if (cnt == 5'd15) begin
                        cnt   <= 5'd0;
                        state <= S_LEVEL;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_LEVEL: begin
                    bcd_l         <= {bcd_l_adj[10:0], shadow[23]};
                    shadow[23:16] <= {shadow[22:16], 1'b0};
                    if (cnt == 5'd7) begin
                        cnt   <= 5'd0;
                        state <= S_COMMIT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_COMMIT: begin
                    hex0  <= pat_s[0];
                    hex1  <= pat_s[1];
                    hex2  <= pat_s[2];
                    hex3  <= pat_s[3];
                    hex4  <= pat_s[4];
                    hex5  <= pat_l[0];
                    hex6  <= pat_l[1];
                    hex7  <= pat_l[2];
                    last  <= capt;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display (ACTIVE_LOW = 1, BLANK_LZ = 1).
// Stimulus pushes the expected display into exp_q; a negedge monitor pops and
// compares whenever done is seen.
module tb_score_display;

    logic        clk;
    logic        rst;
    logic [15:0] score;
    logic [7:0]  level;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    logic [55:0] exp_q[$];
    int checks;
    int errors;
    int done_cnt;

    score_display #(.ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .score(score), .level(level),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] ref_pat(input int d, input bit blank);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; default: p = 7'h6F;
        endcase
        if (blank) p = 7'h00;
        return ~p;
    endfunction

    // Display image for {level, score}: hexN occupies bits [7N+6:7N].
    function automatic logic [55:0] ref_display(input int s, input int l);
        logic [55:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[7*i +: 7] = ref_pat((s / p) % 10, (i > 0) && (s < p));
            p = p * 10;
        end
        p = 1;
        for (int i = 0; i < 3; i++) begin
            r[7*(5+i) +: 7] = ref_pat((l / p) % 10, (i > 0) && (l < p));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [55:0] dut_display();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got display %0h expected no commit", dut_display());
            end else begin
                logic [55:0] e;
                e = exp_q.pop_front();
                if (dut_display() !== e) begin
                    errors++;
                    $display("FAIL commit_display: got %0h expected %0h", dut_display(), e);
                end
            end
            check("busy_low_at_done", 64'(busy), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input int s, input int l);
        @(posedge clk);
        #1;
        score = 16'(s);
        level = 8'(l);
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic run_value(input int s, input int l, input string name);
        int target;
        target = done_cnt + 1;
        exp_q.push_back(ref_display(s, l));
        apply(s, l);
        wait_dones(target, 60, name);
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int got;
        int s, l, prev_s, prev_l, base;
        checks = 0; errors = 0; done_cnt = 0; got = 0;
        rst = 1'b1; score = '0; level = '0;

        // Reset with 0/0: reset display, idle, no done.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_display", 64'(dut_display()), 64'(ref_display(0, 0)));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_busy_zero", 64'(busy), 64'd0);
        check("idle_no_done", 64'(done_cnt), 64'd0);

        // Reset release with level = 1: busy after next edge, done 26 cycles after release.
        @(posedge clk); #1 rst = 1'b1; level = 8'd1; score = 16'd0;
        repeat (2) @(posedge clk);
        exp_q.push_back(ref_display(0, 1));
        #1 rst = 1'b0;
        @(negedge clk);
        check("busy_before_e0", 64'(busy), 64'd0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_after_e0", 64'(busy), 64'd1);
            if (done === 1'b1) begin
                got = i;
                break;
            end
        end
        check("done_latency", 64'(got), 64'd26);
        @(posedge clk);

        // Directed values.
        run_value(12345, 2, "wait_12345");
        run_value(65535, 255, "wait_65535");
        run_value(0, 0, "wait_zero");
        run_value(100, 10, "wait_100");

        // Mid-conversion change 10 -> 20: first commit shows 10, second 20.
        base = done_cnt;
        exp_q.push_back(ref_display(10, 3));
        exp_q.push_back(ref_display(20, 3));
        apply(10, 3);
        repeat (5) @(posedge clk);   // E0 .. E4
        @(posedge clk); #1 score = 16'd20;
        wait_dones(base + 1, 60, "wait_first_of_two");
        @(negedge clk);
        check("restart_after_done", 64'(busy), 64'd1);
        wait_dones(base + 2, 60, "wait_second_of_two");
        @(posedge clk);

        // Change during busy that reverts before IDLE: one commit only.
        base = done_cnt;
        exp_q.push_back(ref_display(777, 7));
        apply(777, 7);
        repeat (3) @(posedge clk);
        #1 score = 16'd999;
        repeat (7) @(posedge clk);
        #1 score = 16'd777;
        wait_dones(base + 1, 60, "wait_revert");
        repeat (30) @(posedge clk);
        check("revert_single_commit", 64'(done_cnt), 64'(base + 1));

        // Randomised values.
        prev_s = 777; prev_l = 7;
        for (int k = 0; k < 10; k++) begin
            s = int'($urandom_range(0, 65535));
            l = int'($urandom_range(0, 255));
            if (s == prev_s && l == prev_l) s = s ^ 1;
            run_value(s, l, "wait_random");
            prev_s = s; prev_l = l;
        end

        // Reset at E10 of a conversion: abandoned, reset display, busy low.
        base = done_cnt;
        apply(5000, 9);
        repeat (10) @(posedge clk);  // E0 .. E9
        @(posedge clk); #1 rst = 1'b1; score = '0; level = '0;
        @(negedge clk);
        check("midrst_busy_pre", 64'(state_dbg != 2'd0), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_display", 64'(dut_display()), 64'(ref_display(0, 0)));
        repeat (35) @(posedge clk);
        check("midrst_no_commit", 64'(done_cnt), 64'(base));
        check("midrst_idle_busy", 64'(busy), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer end of the score/level outputs that the game logic produces.
- Watches score[15:0] and level[7:0]. When either changes, it converts both to BCD serially using shift-add-3 (double-dabble), one shift per clk.
- After conversion it commits eight 7-segment digit patterns: 5 for score, 3 for level.
- Sits at top level beside the VGA path and drives the board HEX displays.

Parameters:
- ACTIVE_LOW, 1, 1 = segment outputs inverted (segment on = 0); 0 = segment on = 1.
- BLANK_LZ, 1, 1 = blank leading zeros within each group (score, level); the least-significant digit of each group is always shown.

Ports:
- clk  in  1  system clock, 50 MHz; sole clock.
- rst  in  1  reset; synchronous, active-high.
- score  in  16  binary score from scorer.
- level  in  8  binary level from scorer.
- hex0..hex4  out  7 each  score digits; hex0 = ones, hex4 = ten-thousands.
- hex5..hex7  out  7 each  level digits; hex5 = ones, hex7 = hundreds.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse in the cycle after a commit.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Segment encoding: bit0 = a … bit6 = g.
  - Active-high patterns 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - ACTIVE_LOW inverts every pattern. Blank = all segments off (7F when ACTIVE_LOW = 1).
- States: IDLE, SCORE, LEVEL, COMMIT.
- Registers:
  - last[23:0]: last committed {level, score}.
  - shadow[23:0]: value being converted.
  - bcd_s[19:0]: 5 score nibbles.
  - bcd_l[11:0]: 3 level nibbles.
  - cnt[4:0]: shift counter.
- IDLE (edge E0): if {level, score} != last, then shadow <= inputs, bcd_s <= 0, bcd_l <= 0, cnt <= 0, go to SCORE. Otherwise stay in IDLE.
- SCORE (edges E1..E16), one step per edge:
  - add 3 to every bcd_s nibble >= 5;
  - shift bcd_s left 1, shifting in shadow[15];
  - shift shadow[15:0] left 1.
  - Go to LEVEL when cnt = 15; cnt resets to 0.
- LEVEL (edges E17..E24): same step on bcd_l using shadow[23:16]. Go to COMMIT when cnt = 7.
- COMMIT (edge E25):
  - hex0..hex7 <= encoded digits with blanking applied;
  - last <= value captured at E0;
  - done <= 1 for exactly one cycle;
  - go to IDLE.
- Latency: outputs reflect a new value 25 cycles after the capture edge. Minimum spacing between commits is 26 cycles.
- busy: high from after E0 until after E25. busy = 0 in IDLE.
- Changes to score or level during busy are ignored. The inputs are resampled in IDLE against last, so the final value is always displayed.
- Inputs that return to the old value before the next IDLE cause no new conversion.
- Blanking (BLANK_LZ = 1): a digit is blank if it is zero and all higher digits in its group are zero. hex0 and hex5 are never blank.
- Reset, including mid-conversion:
  - state = IDLE, busy = 0, done = 0, last = 0, bcd_s = bcd_l = shadow = cnt = 0;
  - hex0 and hex5 show '0'; hex1..hex4 and hex6..hex7 show '0' if BLANK_LZ = 0, else blank;
  - a conversion in progress is abandoned with no commit.
- rst has priority over all other logic.
- Arithmetic: all adds are 4-bit per nibble with no overflow. 65535 fits in 5 digits and 255 fits in 3 digits.

Test Plan (ACTIVE_LOW = 1, BLANK_LZ = 1):
- Assert rst, release it with score = 0, level = 0. Required: hex0 = 40, hex5 = 40, hex1..4 and hex6..7 = 7F, busy = 0, no done.
- rst released with level = 1, score = 0. Required: busy rises after the next edge; done pulses 26 cycles after release; hex5 = 79, hex0 = 40, all other digits 7F.
- score = 12345, level = 2. Required: hex4..hex0 = 79 24 30 19 12; hex5 = 24; hex6..7 = 7F; exactly one done pulse.
- score = 65535, level = 255. Required: hex4..hex0 = 02 12 12 30 12; hex7..hex5 = 24 12 12.
- Change score from 10 to 20 at E5 of a conversion. Required:
  - first commit shows the value captured at E0 (10: hex1 = 79, hex0 = 40);
  - a second conversion starts the cycle after done;
  - second commit shows 20 (hex1 = 24, hex0 = 40).
- Assert rst at E10 of a conversion. Required: no done pulse; outputs equal the reset values; busy = 0 the cycle after rst.
